// File: rtl/vector_cache_pkg.sv
// Shared vector cache types and constants used by the evict transmitter.
package vector_cache_pkg;

   localparam int unsigned BUS_WIDTH      = 128;
   localparam int unsigned EV_LINE_WIDTH  = 1024;
   localparam int unsigned EV_BEATS       = 1024 / BUS_WIDTH;

   localparam int unsigned TAG_WIDTH      = 15;
   localparam int unsigned INDEX_WIDTH    = 8;
   localparam int unsigned OFFSET_WIDTH   = 9;
   localparam int unsigned ROB_ID_WIDTH   = 6;
   localparam int unsigned DB_ID_WIDTH    = 4;
   localparam int unsigned TXNID_WIDTH    = 8;
   localparam int unsigned SIDEBAND_WIDTH = 4;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]    tag;
      logic [INDEX_WIDTH-1:0]  index;
      logic [OFFSET_WIDTH-1:0] offset;
   } vc_addr_t;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]      tag;
      logic [INDEX_WIDTH-1:0]    index;
      logic [OFFSET_WIDTH-1:0]   offset;
      logic [ROB_ID_WIDTH-1:0]   rob_entry_id;
      logic [DB_ID_WIDTH-1:0]    db_entry_id;
      logic [TXNID_WIDTH-1:0]    txnid;
      logic [SIDEBAND_WIDTH-1:0] sideband;
   } arb_out_req_t;

   typedef struct packed {
      logic [EV_LINE_WIDTH-1:0] evict_data;
      arb_out_req_t             evict_req_pld;
   } ram_to_evdb_pld_t;

   typedef struct packed {
      logic [BUS_WIDTH-1:0]      data;
      vc_addr_t                  addr;
      logic                      last;
      logic [ROB_ID_WIDTH-1:0]   rob_entry_id;
      logic [DB_ID_WIDTH-1:0]    db_entry_id;
      logic [TXNID_WIDTH-1:0]    txnid;
      logic [SIDEBAND_WIDTH-1:0] sideband;
   } evict_to_ds_pld_t;

   typedef enum logic {
      StIdle,
      StSend
   } evtx_state_e;

endpackage

// File: rtl/vc_evict_line_fifo.sv
// Line storage for the evict transmitter: DEPTH whole-line slots, head/tail pointers, count.
module vc_evict_line_fifo
   import vector_cache_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  ram_to_evdb_pld_t push_pld,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output ram_to_evdb_pld_t head_pld,
   output logic [CNT_W-1:0] count
);

   ram_to_evdb_pld_t slots_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d;

   // Slot write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         slots_q[tail_q] <= push_pld;
      end
   end

   // Next occupancy: simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_pld = slots_q[head_q];

endmodule

// File: rtl/vc_evict_tx.sv
// Evict transmitter: buffers whole evicted lines and serializes each into BEATS downstream beats.
// Optional feature macro: VC_EVTX_STATS_EN adds the evict_line_cnt port and counter.
module vc_evict_tx
   import vector_cache_pkg::*;
#(
   parameter int unsigned LINE_W = EV_LINE_WIDTH,
   parameter int unsigned BUS_W  = BUS_WIDTH,
   parameter int unsigned BEATS  = LINE_W / BUS_W,
   parameter int unsigned DEPTH  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             evdb_vld,
   output logic             evdb_rdy,
   input  ram_to_evdb_pld_t evdb_pld,
   output logic             ds_vld,
   input  logic             ds_rdy,
   output evict_to_ds_pld_t ds_pld,
   output logic             busy
`ifdef VC_EVTX_STATS_EN
   ,
   output logic [31:0]      evict_line_cnt
`endif
);

   localparam int unsigned BEAT_W = $clog2(BEATS);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic             push, pop;
   logic             full, empty;
   logic [CNT_W-1:0] count;
   ram_to_evdb_pld_t head_pld;

   evtx_state_e       state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              send;
   logic              last_beat;

   logic [BEATS-1:0][BUS_W-1:0] line_beats;
   logic [OFFSET_WIDTH-1:0]     beat_off;

   vc_evict_line_fifo #(
      .DEPTH (DEPTH)
   ) u_line_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_pld (evdb_pld),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .head_pld (head_pld),
      .count    (count)
   );

   // Ready depends only on registered occupancy; a slot freed this cycle shows next cycle.
   assign evdb_rdy = !rst && !full;
   assign push     = evdb_vld && evdb_rdy;
   assign busy     = !rst && !empty;

   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

   // Head FSM and beat counter next-state; pop only on the last-beat handshake.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      pop     = 1'b0;
      send    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (push || (count != '0)) begin
               state_d = StSend;
            end
         end
         StSend: begin
            send = 1'b1;
            if (ds_rdy) begin
               if (last_beat) begin
                  beat_d = '0;
                  pop    = 1'b1;
                  // A line arriving as the final one drains keeps the stream going.
                  if ((count == CNT_W'(1)) && !push) begin
                     state_d = StIdle;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and beat counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   assign ds_vld     = send && !rst;
   assign line_beats = head_pld.evict_data;
   assign beat_off   = OFFSET_WIDTH'(beat_q) * OFFSET_WIDTH'(BUS_W / 8);

   // Beat mux: slice the head line and advance the byte offset; zero when no beat is offered.
   always_comb begin
      ds_pld = '0;
      if (ds_vld) begin
         ds_pld.data         = line_beats[beat_q];
         ds_pld.addr.tag     = head_pld.evict_req_pld.tag;
         ds_pld.addr.index   = head_pld.evict_req_pld.index;
         ds_pld.addr.offset  = head_pld.evict_req_pld.offset + beat_off;
         ds_pld.last         = last_beat;
         ds_pld.rob_entry_id = head_pld.evict_req_pld.rob_entry_id;
         ds_pld.db_entry_id  = head_pld.evict_req_pld.db_entry_id;
         ds_pld.txnid        = head_pld.evict_req_pld.txnid;
         ds_pld.sideband     = head_pld.evict_req_pld.sideband;
      end
   end

`ifdef VC_EVTX_STATS_EN
   logic [31:0] line_cnt_q;

   // Completed-line counter, wraps at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_cnt_q <= '0;
      end else if (pop) begin
         line_cnt_q <= line_cnt_q + 32'd1;
      end
   end

   assign evict_line_cnt = rst ? 32'd0 : line_cnt_q;
`endif

endmodule

// File: doc/vc_evict_tx.md
# vc_evict_tx

Evict transmitter for the vector cache. Accepts whole evicted lines from the eviction data buffer as `ram_to_evdb_pld_t` (1024-bit data plus `arb_out_req_t` command), and stores up to `DEPTH` lines. Each line is serialized into `BEATS` downstream beats of `evict_to_ds_pld_t`, with `last` marking the final beat. The block sits between the EVDB read port and the downstream write channel.

## Interface
- `LINE_W`, 1024: evicted line width in bits.
- `BUS_W`, `BUS_WIDTH` (128): downstream beat width.
- `BEATS`, `LINE_W/BUS_W` (8): beats per line.
- `DEPTH`, 2: line slots; must be a power of two and at least 2.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `evdb_vld` in 1: line offered.
- `evdb_rdy` out 1: slot free.
- `evdb_pld` in `ram_to_evdb_pld_t`: line data and evict command.
- `ds_vld` out 1: beat valid.
- `ds_rdy` in 1: downstream accepts the beat.
- `ds_pld` out `evict_to_ds_pld_t`: beat payload.
- `busy` out 1: at least one slot occupied.
- `evict_line_cnt` out 32: lines fully sent. Present only with `VC_EVTX_STATS_EN`.

## Operation
- Ingress handshake: `evdb_vld && evdb_rdy`. The line is written to the tail slot, and the tail pointer and slot count increment.
- `evdb_rdy = (count < DEPTH)`, computed from registered state only. It never depends on `ds_rdy`.
- Head FSM states:
  - IDLE: count==0. Go to SEND when count becomes nonzero.
  - SEND: the head line is presented beat by beat.
- On the last-beat handshake:
  - If count > 1, stay in SEND with the next line and `beat=0`.
  - If count == 1, go to IDLE.
- Beat counter `beat` is `$clog2(BEATS)` bits wide. It increments on `ds_vld && ds_rdy` and wraps to 0 after `BEATS-1`.
- Beat payload mapping:
  - `data = line[beat*BUS_W +: BUS_W]`, beat 0 is the LSB slice and is sent first.
  - `addr.tag` and `addr.index` come from `evict_req_pld`.
  - `addr.offset = evict_req_pld.offset + beat*(BUS_W/8)`, truncated to `OFFSET_WIDTH` bits (wraps mod 512).
  - `last = (beat == BEATS-1)`.
  - `rob_entry_id`, `db_entry_id`, `txnid` and `sideband` are copied unchanged on every beat.
- Slot count arithmetic:
  - Ingress only: count+1.
  - Last-beat pop only: count−1.
  - Both in the same cycle: count unchanged.
  - Head and tail pointers wrap mod `DEPTH`.
- Full (count==DEPTH):
  - `evdb_rdy=0`, even in a cycle where the last beat of the head line is popped.
  - The freed slot is advertised the following cycle.
- Empty with a simultaneous ingress: the line is written, and `ds_vld` rises the next cycle (no bypass).
- Reset mid-line:
  - All slots are discarded and the partial line is dropped, with no `last` emitted.
  - The FSM returns to IDLE and `beat=0`.

## Timing
- Reset values while `rst` is high: `ds_vld=0`, `evdb_rdy=0`, `busy=0`, `evict_line_cnt=0`, `ds_pld=0`.
- `evdb_rdy=1` from the first cycle after `rst` falls.
- Latency: ingress handshake in cycle N gives `ds_vld` with beat 0 in cycle N+1, if the FIFO was empty.
- With `ds_rdy` held high:
  - One beat per cycle.
  - A line occupies exactly `BEATS` cycles.
  - Back-to-back lines have zero bubbles: beat 0 of the next line follows its predecessor's last beat on the next cycle.
- `ds_vld` and `ds_pld` stay stable while `ds_vld && !ds_rdy`. `ds_vld` is never withdrawn before its handshake.
- All outputs are registered or decoded from registered state. There is no combinational path from `evdb_vld` or `ds_rdy` to any output.

## Configuration
- With `VC_EVTX_STATS_EN` defined:
  - Port `evict_line_cnt` exists.
  - It increments by 1 on each last-beat handshake, wraps at 2^32, and resets to 0.
- Without the macro:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `vector_cache_pkg` gains localparam `EV_BEATS = 1024/BUS_WIDTH`.
- Existing typedefs `ram_to_evdb_pld_t` and `evict_to_ds_pld_t` are reused unchanged.
- Sub-module `vc_evict_line_fifo`:
  - Holds the `DEPTH`-slot storage, head/tail pointers and count.
  - Exposes push/pop, full/empty and the head entry.
- `vc_evict_tx` holds the head FSM, the beat counter, the beat mux and the optional stats counter.

## Test plan
- Single line, `data[i*128+:128]=i`, `offset=0x000`, `ds_rdy=1`:
  - 8 beats in 8 consecutive cycles, starting one cycle after accept.
  - Data 0..7 and offsets 0x000, 0x010 … 0x070.
  - `last` set only on beat 7.
- Offset wrap: line with `offset=0x1F0`, so beat 1 offset=0x000 and beat 7 offset=0x060.
- Three lines offered back-to-back with `ds_rdy=0`:
  - Two are accepted.
  - `evdb_rdy=0` until the first line's last-beat handshake.
  - The third line is accepted the cycle after that.
- `ds_rdy` toggled randomly 50%: beat order is preserved, the payload is stable during stalls, and `rob_entry_id`/`txnid` are copied on all beats.
- `rst` asserted after beat 3 of a line:
  - Next cycle `ds_vld=0` and `busy=0`.
  - The next line starts at beat 0 with no stale data.
- With `VC_EVTX_STATS_EN`: 5 lines sent → `evict_line_cnt=5`. Counter reads 0 after reset.
